div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, the unit can accept a request.
REQ-006 SHALL have port op, input, 2, operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port in1, input, 32, dividend (rs1).
REQ-008 SHALL have port in2, input, 32, divisor (rs2).
REQ-009 SHALL have port flush, input, 1, abort any operation in progress.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer takes the result.
REQ-012 SHALL have port result, output, 32, quotient or remainder.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE; used by the hazard unit to stall EX.

Function
REQ-014 SHALL implement a three-state FSM:
- IDLE: in_ready=1.
- CALC: 32 iterations.
- DONE: out_valid=1.
REQ-015 SHALL accept a request when in_valid&&in_ready; on accept it latches op, |in1|, |in2| (absolute value for DIV/REM only) and the sign flags, and enters CALC.
REQ-016 SHALL perform one radix-2 restoring step per CALC cycle, driven by a 6-bit counter loaded with 0 on accept; on the 32nd step it moves to DONE.
REQ-017 SHALL raise out_valid exactly 33 cycles after the accept edge when DIV_FAST_EXC_EN is undefined.
REQ-018 SHALL apply sign fix-up on entry to DONE:
- quotient negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-019 SHALL, on divide-by-zero, return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = in1 (REM and REMU).
REQ-020 SHALL, on signed overflow (in1=0x80000000, in2=0xFFFFFFFF, DIV/REM), return quotient 0x80000000 and remainder 0.
REQ-021 SHALL hold result and out_valid stable in DONE until out_ready=1, then go to IDLE on the next edge.
REQ-022 SHALL provide no bypass from DONE: a new request is accepted at the earliest one cycle after the handshake.
REQ-023 SHALL, when flush=1, go to IDLE on the next edge from any state and drop out_valid.
REQ-024 SHALL not accept a request in a cycle where flush and in_valid are both 1 in IDLE.
REQ-025 SHALL ignore in1, in2 and op while not in IDLE.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, counter=0, result=0, out_valid=0, busy=0 and in_ready=1, regardless of any operation in progress.

Configuration
REQ-027 SHALL support the macro DIV_FAST_EXC_EN:
- Defined: divide-by-zero and signed overflow skip CALC and enter DONE one cycle after accept (out_valid two cycles after the accept edge).
- Undefined: these cases run all 32 iterations; the results are identical in both builds.

Structure
REQ-028 SHALL take the op encodings (DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU), the FSM state typedef and the XLEN constant from the shared package rv32_pkg.
REQ-029 SHALL use one combinational sub-module, div_step:
- inputs: partial remainder, quotient and divisor;
- outputs: the next partial remainder and quotient.

Verification
REQ-030 SHALL cover a basic DIV: DIV 100/3 -> result 33, out_valid at cycle 33; REM 100/3 -> 1.
REQ-031 SHALL cover signed cases: DIV 0xFFFFFF9C(-100)/3 -> 0xFFFFFFDF(-33); REM -> 0xFFFFFFFF(-1).
REQ-032 SHALL cover unsigned cases: DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU 0xFFFFFFFF/2 -> 1.
REQ-033 SHALL cover exceptions in both builds, with latency 33 without DIV_FAST_EXC_EN and 2 with it:
- DIV 100/0 -> 0xFFFFFFFF;
- REM 100/0 -> 100;
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-034 SHALL cover flush: flush at CALC step 10 -> IDLE next cycle, no out_valid; a new request accepted the following cycle completes correctly.
REQ-035 SHALL cover backpressure and reset:
- out_ready held low 5 cycles -> result stable and busy=1 throughout;
- rst_n pulsed mid-CALC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the divider: data width, M-extension
// divide op encodings and the divider FSM state type.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int W = rv32_pkg::XLEN
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] div_in,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] shifted;
  logic [W:0] trial;

  assign shifted = {rem_in, quo_in[W-1]};
  assign trial   = shifted - {1'b0, div_in};

  // trial[W] set means the divisor did not fit: restore and shift in a 0.
  assign rem_out = trial[W] ? shifted[W-1:0] : trial[W-1:0];
  assign quo_out = {quo_in[W-2:0], ~trial[W]};

endmodule

// File: rtl/div_unit.sv
// Iterative 32-cycle RV32M divider (DIV/DIVU/REM/REMU) with valid/ready
// handshakes. Define DIV_FAST_EXC_EN to short-cut divide-by-zero and overflow.
module div_unit #(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  import rv32_pkg::*;

  div_state_t      state_reg, state_next;
  logic [5:0]      cnt_reg;
  logic [XLEN-1:0] rem_reg, quo_reg, divisor_reg, dividend_reg, result_reg;
  logic            rem_op_reg, neg_q_reg, neg_r_reg, dz_reg, ovf_reg;

  logic            accept, signed_op, fast_exit;
  logic [XLEN-1:0] abs1, abs2, rem_step, quo_step, q_fix, r_fix, result_fix;

  assign signed_op = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign abs1      = (signed_op && in1[XLEN-1]) ? (~in1 + 1'b1) : in1;
  assign abs2      = (signed_op && in2[XLEN-1]) ? (~in2 + 1'b1) : in2;
  assign accept    = in_valid && in_ready && !flush;

`ifdef DIV_FAST_EXC_EN
  assign fast_exit = (dz_reg || ovf_reg) && (cnt_reg == 6'd1);
`else
  assign fast_exit = 1'b0;
`endif

  div_step #(.W(XLEN)) u_step (
    .rem_in (rem_reg),
    .quo_in (quo_reg),
    .div_in (divisor_reg),
    .rem_out(rem_step),
    .quo_out(quo_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= DIV_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = DIV_IDLE;
    end else begin
      case (state_reg)
        DIV_IDLE: if (accept) state_next = DIV_CALC;
        // Count 32 marks the fix-up cycle after the last of 32 steps.
        DIV_CALC: if (cnt_reg == 6'd32 || fast_exit) state_next = DIV_DONE;
        DIV_DONE: if (out_ready) state_next = DIV_IDLE;
        default:  state_next = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_reg == DIV_IDLE);
    out_valid = (state_reg == DIV_DONE);
    busy      = (state_reg != DIV_IDLE);
  end

  always_comb begin
    q_fix = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
    r_fix = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
    if (rem_op_reg) begin
      if (dz_reg)       result_fix = dividend_reg;
      else if (ovf_reg) result_fix = '0;
      else              result_fix = r_fix;
    end else begin
      if (dz_reg)       result_fix = '1;
      else if (ovf_reg) result_fix = {1'b1, {(XLEN-1){1'b0}}};
      else              result_fix = q_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      divisor_reg  <= '0;
      dividend_reg <= '0;
      result_reg   <= '0;
      rem_op_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dz_reg       <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (accept) begin
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= abs1;
      divisor_reg  <= abs2;
      dividend_reg <= in1;
      rem_op_reg   <= (op == DIV_OP_REM) || (op == DIV_OP_REMU);
      neg_q_reg    <= signed_op && (in1[XLEN-1] ^ in2[XLEN-1]);
      neg_r_reg    <= signed_op && in1[XLEN-1];
      dz_reg       <= (in2 == '0);
      ovf_reg      <= signed_op && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
    end else if (state_reg == DIV_CALC) begin
      if (cnt_reg != 6'd32) begin
        cnt_reg <= cnt_reg + 6'd1;
        rem_reg <= rem_step;
        quo_reg <= quo_step;
      end
      if (state_next == DIV_DONE) result_reg <= result_fix;
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table through a result scoreboard,
// plus flush, backpressure and reset sequences.
module tb_div_unit;

`ifdef DIV_FAST_EXC_EN
  localparam int EXC_LAT = 2;
`else
  localparam int EXC_LAT = 33;
`endif
  localparam int NRM_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = o;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble operands after accept; the unit must not look at them.
    op = 2'($urandom);
    in1 = $urandom;
    in2 = $urandom;
  endtask

  task automatic wait_result(input string name, input int lat);
    int n = 0;
    logic [31:0] exp;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    check({name, "_latency"}, 32'(n), 32'(lat));
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check(name, result, exp);
    end
    $display("txn %s: result=0x%08h latency=%0d", name, result, n);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'd100,       32'd3,          32'd33,         NRM_LAT};
    vecs[1]  = '{2'b10, 32'd100,       32'd3,          32'd1,          NRM_LAT};
    vecs[2]  = '{2'b00, 32'hFFFFFF9C,  32'd3,          32'hFFFFFFDF,   NRM_LAT};
    vecs[3]  = '{2'b10, 32'hFFFFFF9C,  32'd3,          32'hFFFFFFFF,   NRM_LAT};
    vecs[4]  = '{2'b01, 32'hFFFFFFFF,  32'd2,          32'h7FFFFFFF,   NRM_LAT};
    vecs[5]  = '{2'b11, 32'hFFFFFFFF,  32'd2,          32'd1,          NRM_LAT};
    vecs[6]  = '{2'b00, 32'd100,       32'd0,          32'hFFFFFFFF,   EXC_LAT};
    vecs[7]  = '{2'b10, 32'd100,       32'd0,          32'd100,        EXC_LAT};
    vecs[8]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   EXC_LAT};
    vecs[9]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,   32'd0,          EXC_LAT};
    vecs[10] = '{2'b01, 32'd100,       32'd0,          32'hFFFFFFFF,   EXC_LAT};
    vecs[11] = '{2'b11, 32'd7,         32'd0,          32'd7,          EXC_LAT};
    vecs[12] = '{2'b00, 32'hFFFFFF9C,  32'd0,          32'hFFFFFFFF,   EXC_LAT};
    vecs[13] = '{2'b00, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   NRM_LAT};
    vecs[14] = '{2'b10, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFF,   NRM_LAT};
    vecs[15] = '{2'b01, 32'h80000000,  32'hFFFFFFFF,   32'd0,          NRM_LAT};

    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      start_req(vecs[i].op, vecs[i].a, vecs[i].b);
      exp_q.push_back(vecs[i].exp);
      wait_result($sformatf("vec%0d", i), vecs[i].lat);
    end

    // Flush at CALC step 10, then an immediate follow-up request.
    start_req(2'b00, 32'd100, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    $display("txn flush: in_ready=%0b busy=%0b", in_ready, busy);
    flush = 1'b0;
    start_req(2'b00, 32'd1000, 32'd7);
    exp_q.push_back(32'd142);
    wait_result("post_flush", NRM_LAT);

    // Flush together with in_valid in IDLE must not accept.
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_noaccept_busy", {31'd0, busy}, 32'd0);
    $display("txn flush_with_valid: busy=%0b", busy);
    in_valid = 1'b0;
    flush = 1'b0;

    // Backpressure: result held with busy while out_ready is low.
    out_ready = 1'b0;
    start_req(2'b01, 32'd50, 32'd5);
    exp_q.push_back(32'd10);
    wait_result("bp", NRM_LAT);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_busy%0d", i), {31'd0, busy}, 32'd1);
      check($sformatf("bp_result%0d", i), result, 32'd10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    $display("txn bp_release: out_valid=%0b in_ready=%0b", out_valid, in_ready);

    // Asynchronous reset in the middle of CALC.
    start_req(2'b00, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    $display("txn mid_calc_reset: result=0x%08h busy=%0b", result, busy);
    @(negedge clk);
    rst_n = 1'b1;
    start_req(2'b11, 32'd100, 32'd3);
    exp_q.push_back(32'd1);
    wait_result("post_reset", NRM_LAT);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
